// File: rtl/am_demod_pipelined_if.sv
// Streaming I/Q-in, envelope-out bus for the AM demodulator.
// The master drives samples and the slave returns demodulated results.
interface am_demod_if #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 12
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] inphase;
  logic signed [DATA_WIDTH-1:0] quadrature;
  logic                         mode;
  logic                         out_valid;
  logic [OUT_WIDTH-1:0]         amdemod_out;

  modport master (
    output in_valid, inphase, quadrature, mode,
    input  out_valid, amdemod_out
  );

  modport slave (
    input  in_valid, inphase, quadrature, mode,
    output out_valid, amdemod_out
  );
endinterface

// File: rtl/am_demod_pipelined.sv
// Pipelined AM envelope detector: I^2+Q^2 followed by a non-restoring square root
// with one quotient bit per stage; each sample returns magnitude or power per its mode bit.
module am_demod_pipelined #(
  parameter int DATA_WIDTH = 12,
  parameter int OUT_WIDTH  = 12
) (
  input logic     clk,
  input logic     reset,
  am_demod_if.slave bus
);

  localparam int PW   = 2 * DATA_WIDTH;
  localparam int N    = DATA_WIDTH + 1;
  localparam int RADW = PW + 2;
  localparam int RW   = N + 4;

  logic signed [PW-1:0] sq_i_r;
  logic signed [PW-1:0] sq_q_r;
  logic                 v1_r;
  logic                 m1_r;

  // Entry 0 holds the registered sum; entries 1..N are the square-root stages.
  logic signed [RW-1:0] rem_r [N+1];
  logic [N-1:0]         q_r   [N+1];
  logic [RADW-1:0]      rad_r [N+1];
  logic [PW-1:0]        s_r   [N+1];
  logic [N:0]           valid_r;
  logic [N:0]           mode_r;

  logic signed [RW-1:0] rem_nx [N];
  logic [N-1:0]         q_nx   [N];
  logic [RADW-1:0]      rad_nx [N];

  logic [PW-1:0]        sum_s;
  logic [PW-1:0]        r_ext_s;
  logic [OUT_WIDTH-1:0] result_s;
  logic [OUT_WIDTH-1:0] out_r;
  logic                 out_valid_r;

  assign sum_s = $unsigned(sq_i_r) + $unsigned(sq_q_r);

  always_comb begin
    logic signed [RW-1:0] rem_sh;
    logic signed [RW-1:0] trial_sub;
    logic signed [RW-1:0] trial_add;
    rem_sh    = '0;
    trial_sub = '0;
    trial_add = '0;
    for (int k = 0; k < N; k++) begin
      rem_nx[k] = '0;
      q_nx[k]   = '0;
      rad_nx[k] = '0;
    end
    for (int k = 0; k < N; k++) begin
      rem_sh    = {rem_r[k][RW-3:0], rad_r[k][RADW-1 -: 2]};
      trial_sub = {{(RW-N-2){1'b0}}, q_r[k], 2'b01};
      trial_add = {{(RW-N-2){1'b0}}, q_r[k], 2'b11};
      // Non-restoring step: the sign of the running remainder picks subtract or add.
      if (!rem_r[k][RW-1]) begin
        rem_nx[k] = rem_sh - trial_sub;
      end else begin
        rem_nx[k] = rem_sh + trial_add;
      end
      q_nx[k]   = {q_r[k][N-2:0], ~rem_nx[k][RW-1]};
      rad_nx[k] = {rad_r[k][RADW-3:0], 2'b00};
    end
  end

  assign r_ext_s = {{(PW-N){1'b0}}, q_r[N]};

  always_comb begin
    result_s = r_ext_s[OUT_WIDTH-1:0];
    if (mode_r[N]) begin
      result_s = s_r[N][PW-1 -: OUT_WIDTH];
    end else begin
      result_s = r_ext_s[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    sq_i_r   <= PW'(bus.inphase) * PW'(bus.inphase);
    sq_q_r   <= PW'(bus.quadrature) * PW'(bus.quadrature);
    rem_r[0] <= '0;
    q_r[0]   <= '0;
    rad_r[0] <= {2'b00, sum_s};
    s_r[0]   <= sum_s;
    for (int k = 0; k < N; k++) begin
      rem_r[k+1] <= rem_nx[k];
      q_r[k+1]   <= q_nx[k];
      rad_r[k+1] <= rad_nx[k];
      s_r[k+1]   <= s_r[k];
    end
  end

  // Valid/mode shift chain and output register; the output holds between valid slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_r        <= 1'b0;
      m1_r        <= 1'b0;
      valid_r     <= '0;
      mode_r      <= '0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else begin
      v1_r        <= bus.in_valid;
      m1_r        <= bus.mode;
      valid_r     <= {valid_r[N-1:0], v1_r};
      mode_r      <= {mode_r[N-1:0], m1_r};
      out_valid_r <= valid_r[N];
      if (valid_r[N]) begin
        out_r <= result_s;
      end else begin
        out_r <= out_r;
      end
    end
  end

  assign bus.out_valid   = out_valid_r;
  assign bus.amdemod_out = out_r;

endmodule

// File: tb/tb_am_demod_pipelined.sv
// Randomized self-checking bench: a floor-sqrt / power reference model with an
// expected-output queue, checked every cycle, plus directed corner cases.
module tb_am_demod_pipelined;

  localparam int DW  = 12;
  localparam int OW  = 12;
  localparam int LAT = DW + 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  am_demod_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

  am_demod_pipelined #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit exp_valid = 1'b0;
  int exp_out = 0;
  int due_q[$];
  int val_q[$];

  function automatic int ref_result(int i, int q, bit m);
    longint s;
    longint r;
    s = longint'(i) * i + longint'(q) * q;
    if (m) return int'((s >> (2*DW - OW)) & ((longint'(1) << OW) - 1));
    r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return int'(r & ((longint'(1) << OW) - 1));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic put(bit v, int i, int q, bit m);
    bus.in_valid   = v;
    bus.inphase    = DW'(i);
    bus.quadrature = DW'(q);
    bus.mode       = m;
    @(posedge clk);
    #2;
  endtask

  // Reference model: every accepted sample reappears LAT cycles later, in order.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        due_q.delete();
        val_q.delete();
        exp_valid = 1'b0;
        exp_out   = 0;
      end else begin
        exp_valid = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          exp_valid = 1'b1;
          exp_out   = val_q[0];
          void'(due_q.pop_front());
          void'(val_q.pop_front());
        end
        if (bus.in_valid) begin
          due_q.push_back(cyc + LAT - 1);
          val_q.push_back(ref_result(int'($signed(bus.inphase)), int'($signed(bus.quadrature)), bus.mode));
        end
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        check("out_valid", 64'(bus.out_valid), 64'(exp_valid));
        check("amdemod_out", 64'(bus.amdemod_out), 64'(exp_out));
      end
    end
  end

  initial begin
    int dir_i[9] = '{3, 0, -5, -2048, 2047, -2048, -2048, 3, 2047};
    int dir_q[9] = '{4, 0, 12, -2048, 2047, 0, 0, 4, 2047};
    bit dir_m[9] = '{0, 0, 0, 0, 0, 0, 1, 1, 1};
    int lat;

    bus.in_valid = 1'b0;
    bus.inphase = '0;
    bus.quadrature = '0;
    bus.mode = 1'b0;
    reset = 1'b1;
    repeat (3) put(1'b0, 0, 0, 1'b0);
    reset = 1'b0;
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_amdemod_out", 64'(bus.amdemod_out), 64'd0);

    check("model_mag_3_4", 64'(ref_result(3, 4, 1'b0)), 64'd5);
    check("model_mag_m5_12", 64'(ref_result(-5, 12, 1'b0)), 64'd13);
    check("model_mag_min_min", 64'(ref_result(-2048, -2048, 1'b0)), 64'd2896);
    check("model_mag_max_max", 64'(ref_result(2047, 2047, 1'b0)), 64'd2894);
    check("model_mag_min_0", 64'(ref_result(-2048, 0, 1'b0)), 64'd2048);
    check("model_pow_min_0", 64'(ref_result(-2048, 0, 1'b1)), 64'd1024);
    check("model_pow_3_4", 64'(ref_result(3, 4, 1'b1)), 64'd0);
    check("model_pow_max_max", 64'(ref_result(2047, 2047, 1'b1)), 64'd2046);

    for (int k = 0; k < 9; k++) begin
      put(1'b1, dir_i[k], dir_q[k], dir_m[k]);
      put(1'b0, 0, 0, 1'b0);
    end

    for (int k = 0; k < 24; k++) begin
      if (k % 2 == 0) put(1'b1, 3, 4, 1'b0);
      else            put(1'b1, -2048, 0, 1'b1);
    end

    put(1'b1, 5, 12, 1'b0);
    put(1'b0, 1000, -1000, 1'b1);
    put(1'b0, -77, 33, 1'b0);
    put(1'b1, 8, 15, 1'b0);
    put(1'b1, -7, 24, 1'b0);
    repeat (LAT + 2) put(1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 10000; k++) begin
      put($urandom_range(0, 9) != 0,
          int'($urandom_range(0, 4095)) - 2048,
          int'($urandom_range(0, 4095)) - 2048,
          1'($urandom_range(0, 1)));
    end

    for (int k = 0; k < 8; k++) begin
      put(1'b1, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, 1'b0);
    end
    reset = 1'b1;
    put(1'b1, 100, 100, 1'b0);
    reset = 1'b0;
    check("midreset_out_valid", 64'(bus.out_valid), 64'd0);
    check("midreset_amdemod_out", 64'(bus.amdemod_out), 64'd0);

    put(1'b1, 3, 4, 1'b0);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      put(1'b0, 0, 0, 1'b0);
      lat++;
    end
    check("refill_latency", 64'(lat), 64'(LAT));
    check("refill_value", 64'(bus.amdemod_out), 64'd5);

    repeat (LAT + 2) put(1'b0, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
